bike_key_decoder: RTL and testbench

Converts the raw PS/2 scan-code byte stream into per-player direction commands for the light-bike game. It sits between the keyboard controller and the per-bike orientation logic. It strips break (F0) and extended (E0) prefixes and rejects 180° reversals. Each accepted press is held as a pending turn until the game tick commits it.

---
 rtl/bike_key_decoder.sv | 145 ++++++++++++++
 tb/tb_bike_key_decoder.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/bike_key_decoder.sv
// rtl/bike_key_decoder.sv - PS/2 scan-code to per-player light-bike direction decoder
module bike_key_decoder (
    input  logic       clock,
    input  logic       reset,
    input  logic       ps2_key_pressed,
    input  logic [7:0] ps2_key_data,
    input  logic       tick,
    input  logic       round_start,
    input  logic       four_player_mode,
    input  logic [3:0] alive,
    output logic [7:0] cur_dir,
    output logic [3:0] pend_valid,
    output logic [7:0] pend_dir,
    output logic [7:0] last_code
);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_EXT     = 2'd1;
    localparam logic [1:0] ST_BRK     = 2'd2;
    localparam logic [1:0] ST_EXT_BRK = 2'd3;

    // P4=up, P3=down, P2=left, P1=right
    localparam logic [7:0] DEFAULT_DIRS = 8'b00_10_11_01;
    localparam logic [7:0] CODE_EXT     = 8'hE0;
    localparam logic [7:0] CODE_BRK     = 8'hF0;

    logic [1:0] state;
    logic [1:0] state_next;
    logic       key_prev;
    logic       byte_event;
    logic       is_ext;
    logic       is_brk;
    logic       in_break;
    logic       make_event;

    logic       key_hit;
    logic [1:0] key_player;
    logic [1:0] key_dir;

    logic [3:0] commit;
    logic [3:0] accept;
    logic [7:0] ref_dir;

    assign byte_event = ps2_key_pressed & ~key_prev;
    assign is_ext     = (ps2_key_data == CODE_EXT);
    assign is_brk     = (ps2_key_data == CODE_BRK);
    assign in_break   = (state == ST_BRK) || (state == ST_EXT_BRK);
    assign make_event = byte_event & ~is_ext & ~is_brk & ~in_break;

    // E0 always (re)enters EXT; a repeated F0 leaves the break state unchanged
    always_comb begin
        state_next = state;
        if (byte_event) begin
            if (is_ext) begin
                state_next = ST_EXT;
            end else if (is_brk) begin
                case (state)
                    ST_IDLE: state_next = ST_BRK;
                    ST_EXT:  state_next = ST_EXT_BRK;
                    default: state_next = state;
                endcase
            end else begin
                state_next = ST_IDLE;
            end
        end
    end

    always_comb begin
        key_hit    = 1'b0;
        key_player = 2'd0;
        key_dir    = 2'd0;
        case (ps2_key_data)
            8'h1D: begin key_hit = 1'b1; key_player = 2'd0; key_dir = 2'd0; end
            8'h23: begin key_hit = 1'b1; key_player = 2'd0; key_dir = 2'd1; end
            8'h1B: begin key_hit = 1'b1; key_player = 2'd0; key_dir = 2'd2; end
            8'h1C: begin key_hit = 1'b1; key_player = 2'd0; key_dir = 2'd3; end
            8'h2C: begin key_hit = 1'b1; key_player = 2'd1; key_dir = 2'd0; end
            8'h33: begin key_hit = 1'b1; key_player = 2'd1; key_dir = 2'd1; end
            8'h34: begin key_hit = 1'b1; key_player = 2'd1; key_dir = 2'd2; end
            8'h2B: begin key_hit = 1'b1; key_player = 2'd1; key_dir = 2'd3; end
            8'h43: begin key_hit = 1'b1; key_player = 2'd2; key_dir = 2'd0; end
            8'h4B: begin key_hit = 1'b1; key_player = 2'd2; key_dir = 2'd1; end
            8'h42: begin key_hit = 1'b1; key_player = 2'd2; key_dir = 2'd2; end
            8'h3B: begin key_hit = 1'b1; key_player = 2'd2; key_dir = 2'd3; end
            8'h75: begin key_hit = 1'b1; key_player = 2'd3; key_dir = 2'd0; end
            8'h74: begin key_hit = 1'b1; key_player = 2'd3; key_dir = 2'd1; end
            8'h73: begin key_hit = 1'b1; key_player = 2'd3; key_dir = 2'd2; end
            8'h6B: begin key_hit = 1'b1; key_player = 2'd3; key_dir = 2'd3; end
            default: begin end
        endcase
    end

    // Turn legality is judged against the direction in force after this cycle's commit
    always_comb begin
        commit  = '0;
        accept  = '0;
        ref_dir = '0;
        for (int p = 0; p < 4; p++) begin
            commit[p]        = tick & pend_valid[p];
            ref_dir[2*p +: 2] = commit[p] ? pend_dir[2*p +: 2] : cur_dir[2*p +: 2];
            accept[p]        = make_event & key_hit
                             & (key_player == 2'(p))
                             & alive[p]
                             & ((p < 2) | four_player_mode)
                             & (key_dir != ref_dir[2*p +: 2])
                             & (key_dir != (ref_dir[2*p +: 2] ^ 2'b10));
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= ST_IDLE;
            key_prev   <= 1'b0;
            cur_dir    <= DEFAULT_DIRS;
            pend_dir   <= DEFAULT_DIRS;
            pend_valid <= 4'b0000;
            last_code  <= 8'h00;
        end else begin
            key_prev <= ps2_key_pressed;
            if (round_start) begin
                state      <= ST_IDLE;
                cur_dir    <= DEFAULT_DIRS;
                pend_dir   <= DEFAULT_DIRS;
                pend_valid <= 4'b0000;
            end else begin
                state <= state_next;
                for (int p = 0; p < 4; p++) begin
                    if (commit[p]) begin
                        cur_dir[2*p +: 2] <= pend_dir[2*p +: 2];
                    end
                    if (accept[p]) begin
                        pend_dir[2*p +: 2] <= key_dir;
                        pend_valid[p]      <= 1'b1;
                    end else if (commit[p] || !alive[p]) begin
                        pend_valid[p] <= 1'b0;
                    end
                end
                if (|accept) begin
                    last_code <= ps2_key_data;
                end
            end
        end
    end

endmodule

// File: tb/tb_bike_key_decoder.sv
// tb/tb_bike_key_decoder.sv - scoreboard bench for bike_key_decoder with a per-player reference model
`timescale 1ns/1ps
module tb_bike_key_decoder;

    logic       clock = 1'b0;
    logic       reset;
    logic       ps2_key_pressed;
    logic [7:0] ps2_key_data;
    logic       tick;
    logic       round_start;
    logic       four_player_mode;
    logic [3:0] alive;
    logic [7:0] cur_dir;
    logic [3:0] pend_valid;
    logic [7:0] pend_dir;
    logic [7:0] last_code;

    bike_key_decoder dut (
        .clock            (clock),
        .reset            (reset),
        .ps2_key_pressed  (ps2_key_pressed),
        .ps2_key_data     (ps2_key_data),
        .tick             (tick),
        .round_start      (round_start),
        .four_player_mode (four_player_mode),
        .alive            (alive),
        .cur_dir          (cur_dir),
        .pend_valid       (pend_valid),
        .pend_dir         (pend_dir),
        .last_code        (last_code)
    );

    always #50 clock = ~clock;

    typedef struct {
        logic [7:0] cur;
        logic [7:0] pdir;
        logic [3:0] pv;
        logic [7:0] last;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    bit   done     = 1'b0;

    // keymap[player][direction]
    logic [7:0] keymap [4][4] = '{'{8'h1D, 8'h23, 8'h1B, 8'h1C},
                                  '{8'h2C, 8'h33, 8'h34, 8'h2B},
                                  '{8'h43, 8'h4B, 8'h42, 8'h3B},
                                  '{8'h75, 8'h74, 8'h73, 8'h6B}};
    int def_dir [4] = '{1, 3, 2, 0};

    int         m_cur  [4];
    int         m_pend [4];
    bit         m_pv   [4];
    bit         m_cm   [4];
    logic [7:0] m_last;
    bit         m_prev;
    bit         m_brk;
    bit         m_ev;
    int         m_hp;
    int         m_hd;
    int         m_rd;
    exp_t       m_e;

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
        end
    endtask

    // Reference model: each player is just a committed and a pending direction
    always @(posedge clock) begin
        if (reset) begin
            for (int p = 0; p < 4; p++) begin
                m_cur[p] = def_dir[p]; m_pend[p] = def_dir[p]; m_pv[p] = 0;
            end
            m_last = 8'h00; m_prev = 0; m_brk = 0;
        end else begin
            m_ev   = ps2_key_pressed && !m_prev;
            m_prev = ps2_key_pressed;
            if (round_start) begin
                for (int p = 0; p < 4; p++) begin
                    m_cur[p] = def_dir[p]; m_pend[p] = def_dir[p]; m_pv[p] = 0;
                end
                m_brk = 0;
            end else begin
                for (int p = 0; p < 4; p++) m_cm[p] = tick && m_pv[p];
                m_hp = -1; m_hd = 0;
                if (m_ev) begin
                    if (ps2_key_data == 8'hE0) m_brk = 0;
                    else if (ps2_key_data == 8'hF0) m_brk = 1;
                    else begin
                        if (!m_brk)
                            for (int p = 0; p < 4; p++)
                                for (int d = 0; d < 4; d++)
                                    if (keymap[p][d] == ps2_key_data) begin m_hp = p; m_hd = d; end
                        m_brk = 0;
                    end
                end
                for (int p = 0; p < 4; p++) begin
                    m_rd = m_cm[p] ? m_pend[p] : m_cur[p];
                    if (m_cm[p]) begin m_cur[p] = m_pend[p]; m_pv[p] = 0; end
                    if (m_hp == p && alive[p] && (p < 2 || four_player_mode)
                        && m_hd != m_rd && m_hd != (m_rd ^ 2)) begin
                        m_pend[p] = m_hd; m_pv[p] = 1; m_last = ps2_key_data;
                    end
                    if (!alive[p]) m_pv[p] = 0;
                end
            end
        end
        for (int p = 0; p < 4; p++) begin
            m_e.cur[2*p +: 2]  = 2'(m_cur[p]);
            m_e.pdir[2*p +: 2] = 2'(m_pend[p]);
            m_e.pv[p]          = m_pv[p];
        end
        m_e.last = m_last;
        exp_q.push_back(m_e);
    end

    initial begin : monitor
        exp_t e;
        while (!done) begin
            @(posedge clock);
            #1;
            if (exp_q.size() == 0) begin
                n_checks++; n_fail++;
                $display("FAIL scoreboard_empty: got no expected entry at %0t", $time);
            end else begin
                e = exp_q.pop_front();
                chk("sb_cur_dir", cur_dir, e.cur);
                chk("sb_pend_dir", pend_dir, e.pdir);
                chk("sb_pend_valid", {4'b0, pend_valid}, {4'b0, e.pv});
                chk("sb_last_code", last_code, e.last);
            end
        end
    end

    task automatic send_byte(input logic [7:0] b, input int hold = 1);
        @(negedge clock); ps2_key_pressed = 1'b1; ps2_key_data = b;
        repeat (hold - 1) @(negedge clock);
        @(negedge clock); ps2_key_pressed = 1'b0;
    endtask

    task automatic pulse_tick();
        @(negedge clock); tick = 1'b1;
        @(negedge clock); tick = 1'b0;
    endtask

    task automatic pulse_round();
        @(negedge clock); round_start = 1'b1;
        @(negedge clock); round_start = 1'b0;
    endtask

    initial begin : stimulus
        reset = 1'b1; ps2_key_pressed = 1'b0; ps2_key_data = 8'h00; tick = 1'b0;
        round_start = 1'b0; four_player_mode = 1'b1; alive = 4'hF;
        repeat (3) @(negedge clock);
        reset = 1'b0;
        chk("reset_cur_dir", cur_dir, 8'h2D);
        chk("reset_pend_dir", pend_dir, 8'h2D);
        chk("reset_pend_valid", {4'b0, pend_valid}, 8'h00);
        chk("reset_last_code", last_code, 8'h00);

        send_byte(8'h1D);
        chk("p1_up_pend_valid", {4'b0, pend_valid}, 8'h01);
        chk("p1_up_pend_dir", {6'b0, pend_dir[1:0]}, 8'h00);
        chk("p1_up_last_code", last_code, 8'h1D);
        repeat (4) @(negedge clock);
        pulse_tick();
        chk("p1_up_commit", {6'b0, cur_dir[1:0]}, 8'h00);

        pulse_round();
        chk("round_cur_dir", cur_dir, 8'h2D);
        send_byte(8'h1C);
        send_byte(8'h23);
        chk("reject_pend_valid", {4'b0, pend_valid}, 8'h00);
        chk("reject_last_code", last_code, 8'h1D);

        send_byte(8'hF0); send_byte(8'h1D);
        chk("break_p1", {4'b0, pend_valid}, 8'h00);
        send_byte(8'hE0); send_byte(8'hF0); send_byte(8'h75);
        chk("ext_break_p4_up", {4'b0, pend_valid}, 8'h00);
        send_byte(8'hE0); send_byte(8'hF0); send_byte(8'h74);
        chk("ext_break_p4_right", {4'b0, pend_valid}, 8'h00);
        send_byte(8'hE0); send_byte(8'h74);
        pulse_tick();
        chk("p4_right_commit", {6'b0, cur_dir[7:6]}, 8'h01);
        send_byte(8'hE0); send_byte(8'h75);
        chk("ext_p4_pend_dir", {6'b0, pend_dir[7:6]}, 8'h00);
        chk("ext_p4_pend_valid", {4'b0, pend_valid}, 8'h08);

        pulse_round();
        four_player_mode = 1'b0;
        send_byte(8'h43);
        chk("mode_gate_p3", {4'b0, pend_valid}, 8'h00);
        four_player_mode = 1'b1;

        send_byte(8'h1D);
        chk("alive_setup", {4'b0, pend_valid}, 8'h01);
        @(negedge clock); alive = 4'hE;
        @(negedge clock);
        chk("dead_drop_pending", {4'b0, pend_valid}, 8'h00);
        send_byte(8'h1B);
        chk("dead_key_ignored", {4'b0, pend_valid}, 8'h00);
        alive = 4'hF;

        pulse_round();
        send_byte(8'h1D);
        @(negedge clock); ps2_key_pressed = 1'b1; ps2_key_data = 8'h1B; tick = 1'b1;
        @(negedge clock); ps2_key_pressed = 1'b0; tick = 1'b0;
        chk("tick_rev_cur", {6'b0, cur_dir[1:0]}, 8'h00);
        chk("tick_rev_pend_valid", {4'b0, pend_valid}, 8'h00);
        pulse_round();
        send_byte(8'h1D);
        @(negedge clock); ps2_key_pressed = 1'b1; ps2_key_data = 8'h1C; tick = 1'b1;
        @(negedge clock); ps2_key_pressed = 1'b0; tick = 1'b0;
        chk("tick_left_cur", {6'b0, cur_dir[1:0]}, 8'h00);
        chk("tick_left_pend_dir", {6'b0, pend_dir[1:0]}, 8'h03);
        chk("tick_left_pend_valid", {4'b0, pend_valid}, 8'h01);

        pulse_round();
        send_byte(8'h2C);
        pulse_tick();
        chk("p2_up_commit", {6'b0, cur_dir[3:2]}, 8'h00);
        send_byte(8'hF0);
        send_byte(8'h2B, 4);
        chk("held_after_break", {4'b0, pend_valid}, 8'h00);
        send_byte(8'h2B, 4);
        chk("held_make_valid", {4'b0, pend_valid}, 8'h02);
        chk("held_make_dir", {6'b0, pend_dir[3:2]}, 8'h03);

        @(negedge clock); round_start = 1'b1; ps2_key_pressed = 1'b1; ps2_key_data = 8'h1D;
        @(negedge clock); round_start = 1'b0; ps2_key_pressed = 1'b0;
        chk("round_drop_valid", {4'b0, pend_valid}, 8'h00);
        chk("round_drop_cur", cur_dir, 8'h2D);
        chk("round_drop_pend", pend_dir, 8'h2D);

        for (int i = 0; i < 3000; i++) begin
            int r;
            @(negedge clock);
            reset            = ($urandom_range(499) == 0);
            round_start      = ($urandom_range(99) == 0);
            tick             = ($urandom_range(7) == 0);
            ps2_key_pressed  = $urandom_range(1);
            if ($urandom_range(199) == 0) four_player_mode = $urandom_range(1);
            if ($urandom_range(49) == 0) alive = ($urandom_range(1) == 0) ? 4'hF : 4'($urandom);
            r = $urandom_range(9);
            if (r < 2)      ps2_key_data = 8'hE0;
            else if (r < 4) ps2_key_data = 8'hF0;
            else if (r < 9) ps2_key_data = keymap[$urandom_range(3)][$urandom_range(3)];
            else            ps2_key_data = 8'($urandom);
        end
        @(negedge clock);
        reset = 1'b0; round_start = 1'b0; tick = 1'b0; ps2_key_pressed = 1'b0;
        repeat (2) @(negedge clock);
        done = 1'b1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
